// File: rtl/eclair_ucode_pkg.sv
// Shared types for the ECLair micro-sequencer: sequencing ops, FSM states and
// the positions of the sequencing fields inside a microword.
package eclair_ucode_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT   = 2'b00,
    SEQ_BRANCH = 2'b01,
    SEQ_CALL   = 2'b10,
    SEQ_RET    = 2'b11
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_COPY = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } seq_state_t;

  // Placement of the sequencing fields within the microword latches
  localparam int SEQ_OP_LSB     = 0;
  localparam int SEQ_OP_WIDTH   = 2;
  localparam int SEQ_TARGET_LSB = SEQ_OP_LSB + SEQ_OP_WIDTH;

endpackage

// File: rtl/ucode_stack.sv
// Micro-return address stack (LIFO). Only the stack pointer is reset; the
// entries themselves are plain storage.
module ucode_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top_data,
  output logic                  full,
  output logic                  empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       top_idx;
  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];

  assign full     = (sp == SP_W'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = sp - SP_W'(1);
  assign top_data = mem[top_idx[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ECLair micro-sequencer: copies EPROM into control store, then steps the micro-PC.
// Optional microword odd-parity checking is enabled by defining ECLAIR_UCODE_PARITY_EN.
module ucode_sequencer
  import eclair_ucode_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    IR_WIDTH    = 8,
  parameter int                    STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = 'hFE
) (
  input  logic                  clk,
  input  logic                  _reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  cs_we,
  output logic [ADDR_WIDTH-1:0] cs_addr,
  output logic [DATA_WIDTH-1:0] cs_wdata,
  input  logic [DATA_WIDTH-1:0] cs_rdata,
  input  logic [IR_WIDTH-1:0]   ir,
  input  logic [1:0]            seq_op,
  input  logic [ADDR_WIDTH-1:0] seq_target,
  input  logic                  cond,
  output logic                  cs_ready,
  output logic                  halted,
  output logic                  stack_err,
  output logic                  parity_err
);

  seq_state_t            state, state_next;
  seq_op_t               op;
  logic [ADDR_WIDTH-1:0] ctr, ctr_next;
  logic [ADDR_WIDTH-1:0] upc, upc_next, upc_inc;
  logic [ADDR_WIDTH-1:0] ir_ext, stack_top;
  logic                  stack_err_next, parity_err_next;
  logic                  push, pop, stack_full, stack_empty, parity_bad;

  assign op      = seq_op_t'(seq_op);
  assign upc_inc = upc + ADDR_WIDTH'(1);

  generate
    if (IR_WIDTH > ADDR_WIDTH) begin : g_ir_trunc
      logic unused_ir_hi;
      assign unused_ir_hi = ^ir[IR_WIDTH-1:ADDR_WIDTH];
      assign ir_ext       = ir[ADDR_WIDTH-1:0];
    end else begin : g_ir_ext
      assign ir_ext = ADDR_WIDTH'(ir);
    end
  endgenerate

  // X or Z anywhere in the microword is treated as a fault as well as even parity
`ifdef ECLAIR_UCODE_PARITY_EN
  assign parity_bad = ((^cs_rdata) !== 1'b1);
`else
  logic unused_rdata;
  assign unused_rdata = ^cs_rdata;
  assign parity_bad   = 1'b0;
`endif

  assign rom_addr = ctr;
  assign cs_we    = (state == ST_COPY);
  assign cs_addr  = (state == ST_COPY) ? ctr : upc;
  assign cs_wdata = rom_data;
  assign cs_ready = (state != ST_COPY);
  assign halted   = (state == ST_HALT);

  ucode_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (_reset),
    .push      (push),
    .pop       (pop),
    .push_data (upc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= ST_COPY;
      ctr          <= '0;
      upc          <= '0;
      stack_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      state        <= state_next;
      ctr          <= ctr_next;
      upc          <= upc_next;
      stack_err    <= stack_err_next;
      parity_err   <= parity_err_next;
    end
  end

  // The halt address wins over both the parity check and the word's own seq_op
  always_comb begin
    state_next      = state;
    ctr_next        = ctr;
    upc_next        = upc;
    stack_err_next  = stack_err;
    parity_err_next = parity_err;
    push            = 1'b0;
    pop             = 1'b0;
    case (state)
      ST_COPY: begin
        ctr_next = ctr + ADDR_WIDTH'(1);
        if (ctr == '1) begin
          state_next = ST_RUN;
          upc_next   = '0;
        end
      end
      ST_RUN: begin
        if (upc == HALT_ADDR) begin
          state_next = ST_HALT;
        end else if (parity_bad) begin
          parity_err_next = 1'b1;
          state_next      = ST_HALT;
        end else begin
          case (op)
            SEQ_NEXT:   upc_next = (seq_target != '0) ? seq_target : ir_ext;
            SEQ_BRANCH: upc_next = cond ? seq_target : upc_inc;
            SEQ_CALL: begin
              if (stack_full) begin
                stack_err_next = 1'b1;
                state_next     = ST_HALT;
              end else begin
                push     = 1'b1;
                upc_next = seq_target;
              end
            end
            SEQ_RET: begin
              if (stack_empty) begin
                stack_err_next = 1'b1;
                state_next     = ST_HALT;
              end else begin
                pop      = 1'b1;
                upc_next = stack_top;
              end
            end
            default: upc_next = upc;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
